plot_sequencer: RTL and testbench
=================================

PLOT_SEQUENCER -- requirements
Module: plot_sequencer
Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low (clk, rst_n).
REQ-002 Parameter TIMEOUT_CYCLES, 32768, max cycles per engine phase before abort.
REQ-003 Parameter CLEAR_FIRST_DEF, 1'b1, value of clear policy used when clear_en tied off (documentation only).
REQ-004 clk  in  1  system clock.
REQ-005 rst_n  in  1  async active-low reset.
REQ-006 start  in  1  run request; held high until done seen.
REQ-007 clear_en  in  1  1 = run fillscreen before circle.
REQ-008 colour  in  3  circle colour.
REQ-009 centre_x  in  8  circle centre x.
REQ-010 centre_y  in  7  circle centre y.
REQ-011 radius  in  8  circle radius.
REQ-012 done  out  1  run complete; held while start high.
REQ-013 timeout  out  1  run aborted by watchdog; valid while done high.
REQ-014 fill_start  out  1  start to fillscreen engine.
REQ-015 fill_done  in  1  done from fillscreen engine.
REQ-016 fill_pix  in  19  t_pixel {plot, x[7:0], y[6:0], colour[2:0]} from fillscreen.
REQ-017 circ_start  out  1  start to circle engine.
REQ-018 circ_done  in  1  done from circle engine.
REQ-019 circ_colour / circ_centre_x / circ_centre_y / circ_radius  out  3/8/7/8  latched circle arguments.
REQ-020 circ_pix  in  19  t_pixel from circle engine.
REQ-021 vga_x / vga_y / vga_colour / vga_plot  out  8/7/3/1  to VGA adapter.
Function
REQ-022 States SHALL be S_IDLE, S_FILL, S_FILL_REL, S_CIRC, S_CIRC_REL, S_DONE (e_seq_state).
REQ-023 S_IDLE: on start=1, latch colour/centre/radius/clear_en; next S_FILL if clear_en=1 else S_CIRC.
REQ-024 S_FILL: fill_start=1; on fill_done=1 -> S_FILL_REL.
REQ-025 S_FILL_REL: fill_start=0; when fill_done=0 -> S_CIRC (engines' done drop after start drops).
REQ-026 S_CIRC: circ_start=1; on circ_done=1 -> S_CIRC_REL; S_CIRC_REL: circ_start=0, when circ_done=0 -> S_DONE.
REQ-027 S_DONE: done=1; on start=0 -> S_IDLE next cycle; start must be seen low before a new run is accepted.
REQ-028 fill_start/circ_start/done SHALL be registered (Moore) outputs; one-cycle latency from triggering input to state change.
REQ-029 VGA mux SHALL be combinational, zero latency: S_FILL selects fill_pix, S_CIRC selects circ_pix, all other states vga_plot=0 and vga_x/y/colour=0.
REQ-030 Plots arriving in *_REL states SHALL be dropped (vga_plot=0).
REQ-031 Latched arguments SHALL stay constant from S_IDLE exit until next S_IDLE entry; input changes mid-run have no effect.
REQ-032 Watchdog counts cycles in S_FILL or S_CIRC, cleared on every phase entry; at count = TIMEOUT_CYCLES-1 without engine done -> S_DONE with timeout=1, engine start dropped.
REQ-033 timeout SHALL clear on S_IDLE entry; counter SHALL saturate, never wrap.
REQ-034 fill_done and circ_done asserted same cycle SHALL be ignored except for the engine of the current state.
Reset
REQ-035 rst_n=0 at any time, including mid-run, SHALL force S_IDLE, counter 0, done/timeout/fill_start/circ_start/vga_plot=0, latched arguments 0.
REQ-036 After reset release, start already high SHALL begin a run on the next clk edge.
Structure
REQ-037 lab_pkg SHALL hold e_seq_state, packed struct t_pixel, and SCREEN_W=160, SCREEN_H=120.
REQ-038 Watchdog SHALL be a sub-module seq_watchdog (clear, enable, expired; parameter TIMEOUT_CYCLES).
Verification
REQ-039 clear_en=1, colour=3'b010, centre (80,60), radius 40 -> 19200 fill plots then circle plots, done=1, timeout=0.
REQ-040 clear_en=0, same args -> no fill_start ever, first vga_plot from circ_pix, done=1.
REQ-041 Change centre_x to 10 during S_CIRC -> circ_centre_x stays 80 until done.
REQ-042 Fill model never asserts fill_done, TIMEOUT_CYCLES=100 -> done=1, timeout=1 at cycle 101 after S_FILL entry, fill_start=0.
REQ-043 rst_n=0 for one cycle mid-S_CIRC -> all outputs 0 immediately; start held high -> new run restarts at S_FILL.
REQ-044 start held high after done -> done stays 1, no second run; start low one cycle then high -> second run.

Source files
------------

// File: rtl/lab_pkg.sv
// Shared types for the plot sequencer slice.
//   e_seq_state : sequencer FSM states
//   t_pixel     : one plot request {plot, x[7:0], y[6:0], colour[2:0]} (19 bits)
//   SCREEN_W/H  : VGA adapter resolution
package lab_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FILL     = 3'd1,
    S_FILL_REL = 3'd2,
    S_CIRC     = 3'd3,
    S_CIRC_REL = 3'd4,
    S_DONE     = 3'd5
  } e_seq_state;

  typedef struct packed {
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } t_pixel;

endpackage

// File: rtl/plot_sequencer_watchdog.sv
// Per-phase cycle watchdog for the plot sequencer.
//   clk, rst_n : clock, async active-low reset
//   clear      : zero the count (phase entry); wins over enable
//   enable     : count this cycle (an engine phase is active)
//   expired    : enable high and count has reached TIMEOUT_CYCLES-1
// The count saturates at TIMEOUT_CYCLES-1 so it can never wrap back to a
// value that would hide an expiry.
module seq_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 32768
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/plot_sequencer.sv
// Plot sequencer: optionally runs the fillscreen engine, then the circle
// engine, muxing whichever engine owns the screen onto the VGA adapter.
//   clk, rst_n                 : clock, async active-low reset
//   start, clear_en            : run request (level), clear-before-circle
//   colour/centre_x/centre_y/radius : circle arguments, latched at run start
//   done, timeout              : run complete / run aborted by watchdog
//   fill_start/fill_done/fill_pix : fillscreen engine handshake and pixels
//   circ_start/circ_done/circ_pix : circle engine handshake and pixels
//   circ_colour/centre_x/centre_y/radius : latched circle arguments
//   vga_x/vga_y/vga_colour/vga_plot : VGA adapter plot port
module plot_sequencer
  import lab_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES  = 32768,
  parameter logic        CLEAR_FIRST_DEF = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       clear_en,
  input  logic [2:0] colour,
  input  logic [7:0] centre_x,
  input  logic [6:0] centre_y,
  input  logic [7:0] radius,
  output logic       done,
  output logic       timeout,
  output logic       fill_start,
  input  logic       fill_done,
  input  t_pixel     fill_pix,
  output logic       circ_start,
  input  logic       circ_done,
  output logic [2:0] circ_colour,
  output logic [7:0] circ_centre_x,
  output logic [6:0] circ_centre_y,
  output logic [7:0] circ_radius,
  input  t_pixel     circ_pix,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  // CLEAR_FIRST_DEF only records the value clear_en is tied to when unused.
  if (TIMEOUT_CYCLES < 2 || $bits(CLEAR_FIRST_DEF) != 1) begin : g_bad_param
    $error("plot_sequencer: TIMEOUT_CYCLES must be at least 2");
  end

  e_seq_state state, next_state;
  logic       wd_clear, wd_enable, wd_expired;
  logic       abort;
  t_pixel     vga_sel;

  // clear_en is consumed by the S_IDLE branch; the chosen path carries it
  // for the rest of the run, so later changes cannot alter the run.
  always_comb begin
    next_state = state;
    abort      = 1'b0;
    case (state)
      S_IDLE:     if (start) next_state = clear_en ? S_FILL : S_CIRC;
      S_FILL: begin
        if (fill_done) begin
          next_state = S_FILL_REL;
        end else if (wd_expired) begin
          next_state = S_DONE;
          abort      = 1'b1;
        end
      end
      S_FILL_REL: if (!fill_done) next_state = S_CIRC;
      S_CIRC: begin
        if (circ_done) begin
          next_state = S_CIRC_REL;
        end else if (wd_expired) begin
          next_state = S_DONE;
          abort      = 1'b1;
        end
      end
      S_CIRC_REL: if (!circ_done) next_state = S_DONE;
      S_DONE:     if (!start) next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  assign wd_enable = (state == S_FILL) || (state == S_CIRC);
  assign wd_clear  = ((next_state == S_FILL) && (state != S_FILL)) ||
                     ((next_state == S_CIRC) && (state != S_CIRC));

  seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  // Handshake outputs are flopped from next_state so they track the state
  // register exactly while staying glitch-free register outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      fill_start    <= 1'b0;
      circ_start    <= 1'b0;
      done          <= 1'b0;
      timeout       <= 1'b0;
      circ_colour   <= '0;
      circ_centre_x <= '0;
      circ_centre_y <= '0;
      circ_radius   <= '0;
    end else begin
      state      <= next_state;
      fill_start <= (next_state == S_FILL);
      circ_start <= (next_state == S_CIRC);
      done       <= (next_state == S_DONE);
      if (next_state == S_IDLE) begin
        timeout <= 1'b0;
      end else if (abort) begin
        timeout <= 1'b1;
      end
      if ((state == S_IDLE) && start) begin
        circ_colour   <= colour;
        circ_centre_x <= centre_x;
        circ_centre_y <= centre_y;
        circ_radius   <= radius;
      end
    end
  end

  // Only the engine owning the current phase reaches the screen; release
  // states blank the port so late plots are dropped.
  always_comb begin
    vga_sel = '0;
    case (state)
      S_FILL:  vga_sel = fill_pix;
      S_CIRC:  vga_sel = circ_pix;
      default: vga_sel = '0;
    endcase
  end

  assign vga_plot   = vga_sel.plot;
  assign vga_x      = vga_sel.x;
  assign vga_y      = vga_sel.y;
  assign vga_colour = vga_sel.colour;

endmodule

// File: tb/tb_plot_sequencer.sv
// Self-checking bench for plot_sequencer: behavioural fill/circle engines,
// an expected-pixel queue built from the run arguments, and per-cycle checks
// of the VGA mux and latched arguments. A second instance with a short
// watchdog exercises the timeout path.
module tb_plot_sequencer;
  import lab_pkg::*;

  localparam int unsigned FILL_N = SCREEN_W * SCREEN_H;
  localparam int unsigned CIRC_N = 24;

  logic       clk = 1'b0;
  logic       rst_n, start, clear_en;
  logic [2:0] colour;
  logic [7:0] centre_x, radius;
  logic [6:0] centre_y;
  logic       done, timeout, fill_start, fill_done, circ_start, circ_done;
  t_pixel     fill_pix, circ_pix;
  logic [2:0] circ_colour, vga_colour;
  logic [7:0] circ_centre_x, circ_radius, vga_x;
  logic [6:0] circ_centre_y, vga_y;
  logic       vga_plot;
  t_pixel     vga_pix;

  logic       w_start, w_done, w_timeout, w_fill_start, w_circ_start, w_vga_plot;
  logic [2:0] w_circ_colour, w_vga_colour;
  logic [7:0] w_circ_cx, w_circ_r, w_vga_x;
  logic [6:0] w_circ_cy, w_vga_y;
  t_pixel     no_pix = '0;

  always #5 clk = ~clk;

  plot_sequencer #(.TIMEOUT_CYCLES(32768), .CLEAR_FIRST_DEF(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear_en(clear_en),
    .colour(colour), .centre_x(centre_x), .centre_y(centre_y), .radius(radius),
    .done(done), .timeout(timeout),
    .fill_start(fill_start), .fill_done(fill_done), .fill_pix(fill_pix),
    .circ_start(circ_start), .circ_done(circ_done),
    .circ_colour(circ_colour), .circ_centre_x(circ_centre_x),
    .circ_centre_y(circ_centre_y), .circ_radius(circ_radius), .circ_pix(circ_pix),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  plot_sequencer #(.TIMEOUT_CYCLES(100), .CLEAR_FIRST_DEF(1'b1)) dut_wd (
    .clk(clk), .rst_n(rst_n), .start(w_start), .clear_en(1'b1),
    .colour(3'd2), .centre_x(8'd80), .centre_y(7'd60), .radius(8'd40),
    .done(w_done), .timeout(w_timeout),
    .fill_start(w_fill_start), .fill_done(1'b0), .fill_pix(no_pix),
    .circ_start(w_circ_start), .circ_done(1'b0),
    .circ_colour(w_circ_colour), .circ_centre_x(w_circ_cx),
    .circ_centre_y(w_circ_cy), .circ_radius(w_circ_r), .circ_pix(no_pix),
    .vga_x(w_vga_x), .vga_y(w_vga_y), .vga_colour(w_vga_colour), .vga_plot(w_vga_plot)
  );

  assign vga_pix = {vga_plot, vga_x, vga_y, vga_colour};

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic t_pixel fill_point(input int unsigned i);
    t_pixel p;
    p.plot   = 1'b1;
    p.x      = 8'(i / SCREEN_H);
    p.y      = 7'(i % SCREEN_H);
    p.colour = 3'd0;
    return p;
  endfunction

  function automatic t_pixel circ_point(input int unsigned i, input logic [7:0] cx,
                                        input logic [6:0] cy, input logic [2:0] c);
    t_pixel p;
    p.plot   = 1'b1;
    p.x      = cx - 8'd12 + 8'(i);
    p.y      = cy + 7'(i % 5);
    p.colour = c;
    return p;
  endfunction

  // Fillscreen engine: one pixel per cycle, then done held until start drops.
  initial begin : fill_engine
    int unsigned idx;
    idx = 0; fill_done = 1'b0; fill_pix = '0;
    forever begin
      @(posedge clk); #1;
      if (!fill_start) begin
        fill_done = 1'b0; fill_pix = '0; idx = 0;
      end else if (fill_done) begin
        fill_pix = '0;
      end else if (idx < FILL_N) begin
        fill_pix = fill_point(idx); idx++;
      end else begin
        fill_pix = '0; fill_done = 1'b1;
      end
    end
  end

  // Circle engine: plots from the latched arguments; after start drops it
  // keeps done one more cycle and presents a stray plot that must not show.
  initial begin : circ_engine
    int unsigned idx;
    bit stray;
    idx = 0; stray = 1'b0; circ_done = 1'b0; circ_pix = '0;
    forever begin
      @(posedge clk); #1;
      if (circ_start) begin
        if (idx < CIRC_N) begin
          circ_pix = circ_point(idx, circ_centre_x, circ_centre_y, circ_colour); idx++;
        end else begin
          circ_pix = '0; circ_done = 1'b1; stray = 1'b1;
        end
      end else if (circ_done && stray) begin
        circ_pix = {1'b1, 8'd1, 7'd1, 3'd7}; stray = 1'b0;
      end else begin
        circ_done = 1'b0; circ_pix = '0; idx = 0; stray = 1'b0;
      end
    end
  end

  t_pixel      exp_q[$];
  bit          sb_en = 1'b0, arg_chk = 1'b0, saw_fill = 1'b0, first_seen = 1'b0;
  t_pixel      first_pix = '0;
  int unsigned plot_cnt = 0;
  logic [2:0]  exp_colour = '0;
  logic [7:0]  exp_cx = '0, exp_r = '0;
  logic [6:0]  exp_cy = '0;

  always @(negedge clk) begin
    t_pixel e;
    if (rst_n) begin
      if (!vga_plot) chk_eq("vga_quiet", 32'({vga_x, vga_y, vga_colour}), 32'd0);
      if (fill_start && fill_pix.plot) chk_eq("mux_fill", 32'(vga_pix), 32'(fill_pix));
      if (circ_start && circ_pix.plot) chk_eq("mux_circ", 32'(vga_pix), 32'(circ_pix));
      if (fill_start) saw_fill = 1'b1;
      if (vga_plot) begin
        plot_cnt++;
        if (!first_seen) begin first_pix = vga_pix; first_seen = 1'b1; end
        if (sb_en) begin
          e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
          chk_eq("stream", 32'(vga_pix), 32'(e));
        end
      end
      if (arg_chk)
        chk_eq("latched_args", 32'({circ_colour, circ_centre_x, circ_centre_y, circ_radius}),
               32'({exp_colour, exp_cx, exp_cy, exp_r}));
    end
  end

  task automatic load_circle();
    for (int unsigned i = 0; i < CIRC_N; i++) exp_q.push_back(circ_point(i, 8'd80, 7'd60, 3'd2));
  endtask

  initial begin : global_bound
    #1_000_000;
    $display("FAIL global_timeout: actual still running required finished");
    $fatal(1, "bench did not finish");
  end

  initial begin : stimulus
    int unsigned n;
    rst_n = 1'b0; start = 1'b0; clear_en = 1'b0; colour = '0;
    centre_x = '0; centre_y = '0; radius = '0; w_start = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("rst_outputs", 32'({done, timeout, fill_start, circ_start, vga_plot}), 32'd0);
    chk_eq("rst_args", 32'({circ_colour, circ_centre_x, circ_centre_y, circ_radius}), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_eq("idle_no_start", 32'({done, fill_start, circ_start}), 32'd0);

    // Watchdog: fill engine never finishes, 100-cycle limit.
    #1 w_start = 1'b1;
    @(negedge clk);
    chk_eq("wd_launch", 32'(w_fill_start), 32'd1);
    n = 0;
    while (w_fill_start && n < 1000) begin @(negedge clk); n++; end
    chk_eq("wd_phase_len", n, 32'd100);
    chk_eq("wd_done", 32'(w_done), 32'd1);
    chk_eq("wd_timeout", 32'(w_timeout), 32'd1);
    chk_eq("wd_starts_low", 32'({w_fill_start, w_circ_start}), 32'd0);
    repeat (3) @(negedge clk);
    chk_eq("wd_timeout_held", 32'({w_done, w_timeout}), 32'd3);
    #1 w_start = 1'b0;
    @(negedge clk);
    chk_eq("wd_timeout_clear", 32'({w_done, w_timeout}), 32'd0);

    // Run 1: clear then circle; circle arguments change mid-circle.
    #1 clear_en = 1'b1; colour = 3'b010; centre_x = 8'd80; centre_y = 7'd60; radius = 8'd40;
    exp_colour = 3'b010; exp_cx = 8'd80; exp_cy = 7'd60; exp_r = 8'd40;
    exp_q.delete();
    for (int unsigned i = 0; i < FILL_N; i++) exp_q.push_back(fill_point(i));
    load_circle();
    plot_cnt = 0; first_seen = 1'b0; sb_en = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk_eq("run1_launch", 32'({fill_start, circ_start}), 32'd2);
    #1 arg_chk = 1'b1;
    n = 0;
    while (!circ_start && n < 25000) begin @(negedge clk); n++; end
    chk_eq("run1_circ_reached", 32'(circ_start), 32'd1);
    #1 centre_x = 8'd10; centre_y = 7'd5; radius = 8'd1; colour = 3'd7;
    n = 0;
    while (!done && n < 1000) begin @(negedge clk); n++; end
    chk_eq("run1_done", 32'(done), 32'd1);
    chk_eq("run1_timeout", 32'(timeout), 32'd0);
    chk_eq("run1_left", exp_q.size(), 32'd0);
    chk_eq("run1_plots", plot_cnt, 32'd19224);
    chk_eq("run1_first", 32'(first_pix), 32'h40000);
    #1 start = 1'b0; arg_chk = 1'b0;
    @(negedge clk);
    chk_eq("run1_idle", 32'(done), 32'd0);

    // Run 2: no clear; done held while start stays high, then a re-run.
    #1 clear_en = 1'b0; colour = 3'b010; centre_x = 8'd80; centre_y = 7'd60; radius = 8'd40;
    load_circle();
    plot_cnt = 0; first_seen = 1'b0; saw_fill = 1'b0;
    start = 1'b1;
    @(negedge clk);
    chk_eq("run2_launch", 32'({fill_start, circ_start}), 32'd1);
    #1 arg_chk = 1'b1;
    n = 0;
    while (!done && n < 200) begin @(negedge clk); n++; end
    chk_eq("run2_done", 32'({done, timeout}), 32'd2);
    chk_eq("run2_left", exp_q.size(), 32'd0);
    chk_eq("run2_plots", plot_cnt, 32'd24);
    chk_eq("run2_first", 32'(first_pix), 32'h511E2);
    chk_eq("run2_no_fill", 32'(saw_fill), 32'd0);
    repeat (10) begin
      @(negedge clk);
      chk_eq("hold_done", 32'({done, circ_start, fill_start}), 32'd4);
    end
    #1 start = 1'b0;
    @(negedge clk);
    chk_eq("rearm_idle", 32'(done), 32'd0);
    load_circle();
    plot_cnt = 0;
    #1 start = 1'b1;
    @(negedge clk);
    chk_eq("rerun_launch", 32'(circ_start), 32'd1);
    n = 0;
    while (!done && n < 200) begin @(negedge clk); n++; end
    chk_eq("rerun_done", 32'(done), 32'd1);
    chk_eq("rerun_plots", plot_cnt, 32'd24);
    chk_eq("rerun_left", exp_q.size(), 32'd0);
    #1 start = 1'b0; arg_chk = 1'b0; sb_en = 1'b0;
    @(negedge clk);

    // Run 3: reset mid-circle with start held, restart goes to fill.
    #1 clear_en = 1'b0; start = 1'b1;
    n = 0;
    while (!circ_start && n < 10) begin @(negedge clk); n++; end
    chk_eq("run3_circ", 32'(circ_start), 32'd1);
    repeat (3) @(negedge clk);
    #2 clear_en = 1'b1; rst_n = 1'b0;
    #1;
    chk_eq("midrst_outputs", 32'({done, timeout, fill_start, circ_start, vga_plot}), 32'd0);
    chk_eq("midrst_args", 32'({circ_colour, circ_centre_x, circ_centre_y, circ_radius}), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_eq("restart_fill", 32'({fill_start, circ_start}), 32'd2);
    #1 rst_n = 1'b0; start = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_eq("final_idle", 32'({done, fill_start, circ_start}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
